gray_converter: RTL
===================

GRAY_CONVERTER -- requirements
Module: gray_converter

Interface
REQ-001 Parameter IMG_W, default 64, image width in pixels.
REQ-002 Parameter IMG_H, default 48, image height in pixels.
REQ-003 Parameter ADDR_W, default 12; SHALL satisfy 2^ADDR_W >= IMG_W*IMG_H.
REQ-004 clk  input  1  clock; all state updates on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 gs_enable  input  1  level enable from the pipeline controller; high for the whole GRAYSCALE phase.
REQ-007 src_rd  output  1  read strobe to the RWM_1 frame memory.
REQ-008 src_addr  output  ADDR_W  RWM_1 pixel address.
REQ-009 src_data  input  24  RGB888 pixel {R[23:16],G[15:8],B[7:0]}, valid exactly 1 cycle after src_rd.
REQ-010 dst_wr  output  1  write strobe to the RWM_2 frame memory.
REQ-011 dst_addr  output  ADDR_W  RWM_2 pixel address.
REQ-012 dst_data  output  8  gray pixel.
REQ-013 gs_done  output  1  frame complete, level.
REQ-014 busy  output  1  high in READ or DRAIN.

Function
REQ-015 FSM states: IDLE, READ, DRAIN, DONE.
REQ-016 IDLE: gs_enable=1 -> READ with read counter cleared to 0.
REQ-017 READ: src_rd=1 every cycle, src_addr = read counter, counter +1 per cycle; after issuing address N-1 (N=IMG_W*IMG_H) -> DRAIN.
REQ-018 Stage 1: src_data registered with its address 1 cycle after src_rd; stage 2: gray registered onto dst_data/dst_addr with dst_wr=1 the following cycle; read-to-write latency 2 cycles.
REQ-019 Gray = (77*R + 150*G + 29*B) >> 8; sum held in 16 bits unsigned; result <= 255, never wraps.
REQ-020 DRAIN: issues no reads; -> DONE in the cycle after the write of address N-1.
REQ-021 DONE: gs_done=1, no strobes; stays until gs_enable=0, then -> IDLE with gs_done=0 the next cycle.
REQ-022 gs_enable=0 in READ or DRAIN: abort -> IDLE next cycle; pipeline valids cleared; no further dst_wr; gs_done stays 0.
REQ-023 Write addresses strictly 0..N-1 in order, exactly N writes per completed frame, one per cycle, no gaps.
REQ-024 Counter wrap: read counter never exceeds N-1; IMG_W*IMG_H = 2^ADDR_W is legal.
REQ-025 gs_enable held high in IDLE after a completed frame (re-entry) starts a new frame only via DONE->IDLE transition, never directly from DONE.

Reset
REQ-026 rst_n=0 asynchronously forces IDLE, counters 0, pipeline valids 0, src_rd=0, dst_wr=0, gs_done=0, busy=0, src_addr=0, dst_addr=0, dst_data=0.
REQ-027 Reset mid-frame discards all in-flight pixels; first cycle after release is IDLE.

Configuration
REQ-028 GRAY_ROUND_EN defined: Gray = (77*R + 150*G + 29*B + 128) >> 8 (round-to-nearest); undefined: truncation per REQ-019. Latency unchanged either way.

Structure
REQ-029 Package gray_pkg holds coefficients (77, 150, 29), rounding constant 128, pixel widths (24, 8), and the FSM state type.
REQ-030 Sub-module gray_mac: 24-bit RGB in, 8-bit gray out, combinational weighted sum, instantiated between stage-1 and stage-2 registers.

Verification
REQ-031 Pixel 0xFFFFFF -> dst_data 0xFF (both configurations).
REQ-032 Pixels 0xFF0000, 0x00FF00, 0x0000FF -> 0x4C, 0x95, 0x1C truncated; 0x4D, 0x95, 0x1D with GRAY_ROUND_EN.
REQ-033 IMG_W=4, IMG_H=2, gs_enable high at cycle 0 -> src_rd cycles 1-8, dst_wr cycles 3-10 addresses 0-7, gs_done from cycle 11 until gs_enable drops.
REQ-034 gs_enable dropped after 3 reads -> at most 3 dst_wr, IDLE next cycle, gs_done never asserted; next gs_enable restarts at address 0.
REQ-035 rst_n asserted mid-READ -> all outputs 0 immediately (same cycle, asynchronous); restart after release writes full frame from address 0.
REQ-036 ADDR_W=3, IMG_W=4, IMG_H=2 (N=2^ADDR_W) -> addresses 0-7 with no wrap, exactly 8 writes, gs_done asserted.

Source files
------------

// File: rtl/gray_pkg.sv
// Shared constants and types for the RGB888 -> 8-bit grayscale converter.
// Luma weights are 8-bit fixed point. They sum to 256, so the weighted sum
// divided by 256 always fits in 8 bits.
package gray_pkg;

  localparam int COEF_R  = 77;
  localparam int COEF_G  = 150;
  localparam int COEF_B  = 29;
  localparam int ROUND_K = 128;

  localparam int RGB_W  = 24;
  localparam int GRAY_W = 8;
  localparam int SUM_W  = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } gs_state_t;

endpackage

// File: rtl/gray_converter_mac.sv
// Combinational weighted sum RGB888 -> gray.
// Macro GRAY_ROUND_EN: when defined, add half an LSB before the shift so the
// result is rounded to nearest. When undefined, the result is truncated.
// The worst case is 255*256 + 128 = 65408, so the 16-bit sum never wraps.
module gray_mac
  import gray_pkg::*;
(
  input  logic [RGB_W-1:0]  rgb,
  output logic [GRAY_W-1:0] gray
);

  logic [SUM_W-1:0] sum;

  // Weighted sum of the three channels, then divide by 256.
  always_comb begin
    sum = SUM_W'(COEF_R) * SUM_W'(rgb[23:16])
        + SUM_W'(COEF_G) * SUM_W'(rgb[15:8])
        + SUM_W'(COEF_B) * SUM_W'(rgb[7:0]);
`ifdef GRAY_ROUND_EN
    sum = sum + SUM_W'(ROUND_K);
`else
    sum = sum;
`endif
    gray = sum[SUM_W-1:8];
  end

endmodule

// File: rtl/gray_converter.sv
// Frame-level grayscale pass: streams N = IMG_W*IMG_H RGB pixels out of RWM_1
// and writes N gray pixels into RWM_2, at one pixel per cycle.
// Macro GRAY_ROUND_EN (used in gray_mac) selects rounding over truncation.
// Latency is the same in both modes.
//
// Strobe semantics: src_rd=1 means "read src_addr this cycle". The memory
// returns src_data exactly one cycle later, and there is no back-pressure.
// dst_wr=1 means "write dst_data to dst_addr this cycle", and the memory
// always accepts the write.
// Pipeline: stage 1 tags the returning src_data with its address. gray_mac
// converts src_data combinationally. Stage 2 registers the result onto the
// dst_* port. From src_rd to dst_wr is 2 cycles.
module gray_converter
  import gray_pkg::*;
#(
  parameter int IMG_W  = 64,
  parameter int IMG_H  = 48,
  parameter int ADDR_W = 12
)
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              gs_enable,
  output logic              src_rd,
  output logic [ADDR_W-1:0] src_addr,
  input  logic [RGB_W-1:0]  src_data,
  output logic              dst_wr,
  output logic [ADDR_W-1:0] dst_addr,
  output logic [GRAY_W-1:0] dst_data,
  output logic              gs_done,
  output logic              busy,
  output gs_state_t         state_dbg
);

  localparam int                N    = IMG_W * IMG_H;
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(N - 1);

  gs_state_t           state;
  gs_state_t           state_nxt;
  logic [ADDR_W-1:0]   rd_cnt;
  logic                s1_valid;
  logic [ADDR_W-1:0]   s1_addr;
  logic [GRAY_W-1:0]   gray;
  logic                abort;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Next state and Moore outputs. Dropping gs_enable while busy aborts the frame.
  always_comb begin
    state_nxt = state;
    src_rd    = 1'b0;
    gs_done   = 1'b0;
    busy      = 1'b0;
    abort     = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (gs_enable) state_nxt = ST_READ;
      end
      ST_READ: begin
        src_rd = 1'b1;
        busy   = 1'b1;
        if (!gs_enable) begin
          abort     = 1'b1;
          state_nxt = ST_IDLE;
        end else if (rd_cnt == LAST) begin
          state_nxt = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        busy = 1'b1;
        if (!gs_enable) begin
          abort     = 1'b1;
          state_nxt = ST_IDLE;
        end else if (dst_wr && dst_addr == LAST) begin
          state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        gs_done = 1'b1;
        if (!gs_enable) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign src_addr  = rd_cnt;
  assign state_dbg = state;

  // Read counter: cleared in IDLE. It saturates at the last address, so it
  // never wraps when N equals 2^ADDR_W.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                rd_cnt <= '0;
    else if (state == ST_IDLE)                 rd_cnt <= '0;
    else if (state == ST_READ && rd_cnt != LAST) rd_cnt <= rd_cnt + 1'b1;
  end

  // Stage 1: tag the pixel returning next cycle with its address.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_addr  <= '0;
    end else begin
      s1_valid <= src_rd & ~abort;
      if (src_rd) s1_addr <= rd_cnt;
    end
  end

  gray_mac u_mac (
    .rgb  (src_data),
    .gray (gray)
  );

  // Stage 2: register the gray pixel onto the write port.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dst_wr   <= 1'b0;
      dst_addr <= '0;
      dst_data <= '0;
    end else begin
      dst_wr <= s1_valid & ~abort;
      if (s1_valid & ~abort) begin
        dst_addr <= s1_addr;
        dst_data <= gray;
      end
    end
  end

endmodule
